// File: rtl/fill_sequencer.sv
// Fill-colour sequencer: walks a small writable palette and offers each
// colour to a display driver through a valid/ready handshake.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_PRESENT | out_color is offered (out_valid=1) and waits for in_ready
// ST_IDLE    | colour accepted; waiting for dwell expiry (AUTO) or in_step (STEP)
module fill_sequencer #(
  parameter int N_COLORS     = 3,
  parameter int COLOR_WIDTH  = 16,
  parameter int DWELL_CYCLES = 16777216,
  parameter logic [N_COLORS*COLOR_WIDTH-1:0] DEFAULT_PALETTE =
    {16'h000f, 16'h03e0, 16'hf800},
  localparam int AW = (N_COLORS > 1) ? $clog2(N_COLORS) : 1
) (
  input  logic                   in_clk,
  input  logic                   in_rst_n,
  input  logic [1:0]             in_mode,
  input  logic                   in_dir,
  input  logic                   in_step,
  input  logic                   in_wr_en,
  input  logic [AW-1:0]          in_wr_addr,
  input  logic [COLOR_WIDTH-1:0] in_wr_data,
  input  logic                   in_ready,
  output logic [COLOR_WIDTH-1:0] out_color,
  output logic                   out_valid,
  output logic [AW-1:0]          out_index
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [AW-1:0] LAST_IDX   = AW'(N_COLORS - 1);
  localparam logic [1:0]    MODE_AUTO  = 2'd0;
  localparam logic [1:0]    MODE_STEP  = 2'd2;

  typedef enum logic {ST_PRESENT = 1'b0, ST_IDLE = 1'b1} state_t;

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [AW-1:0]          r_idx;
  logic [AW-1:0]          w_next_idx;
  logic [COLOR_WIDTH-1:0] r_color;
  logic [COLOR_WIDTH-1:0] w_color_nxt;
  logic [DW-1:0]          r_dwell;
  logic [DW-1:0]          w_dwell_nxt;
  logic [1:0]             r_mode_prev;
  logic                   w_mode_chg;
  logic                   w_advance;
  logic                   w_wr_hit;
  logic [COLOR_WIDTH-1:0] r_palette [N_COLORS];

  // Reset asserts asynchronously, releases two clocks later in the clock domain
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n    = r_rst_sync[1];
  assign w_mode_chg = (in_mode != r_mode_prev);
  assign w_wr_hit   = in_wr_en && (int'(in_wr_addr) < N_COLORS);

  // Index that an advance would move to, wrapping at both ends
  always_comb begin
    w_next_idx = r_idx;
    if (in_dir) w_next_idx = (r_idx == '0) ? LAST_IDX : r_idx - AW'(1);
    else        w_next_idx = (r_idx == LAST_IDX) ? '0 : r_idx + AW'(1);
  end

  // New colour bypasses a same-edge palette write to the target entry
  always_comb begin
    w_color_nxt = r_palette[w_next_idx];
    if (w_wr_hit && (in_wr_addr == w_next_idx)) w_color_nxt = in_wr_data;
  end

  // State register
  always_ff @(posedge in_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_PRESENT;
    else          r_state <= w_state_nxt;
  end

  // Next state, advance decision and dwell counter next value
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    w_dwell_nxt = r_dwell;
    unique case (r_state)
      ST_PRESENT: begin
        w_dwell_nxt = '0;
        if (in_ready) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        case (in_mode)
          MODE_AUTO: begin
            if (w_mode_chg) begin
              w_dwell_nxt = '0;
            end else if (r_dwell == DWELL_LAST) begin
              w_dwell_nxt = '0;
              w_advance   = 1'b1;
            end else begin
              w_dwell_nxt = r_dwell + DW'(1);
            end
          end
          MODE_STEP: begin
            if (w_mode_chg) w_dwell_nxt = '0;
            w_advance = in_step;
          end
          default: begin
            if (w_mode_chg) w_dwell_nxt = '0;
          end
        endcase
        if (w_advance) w_state_nxt = ST_PRESENT;
      end
      default: w_state_nxt = ST_PRESENT;
    endcase
  end

  // Index, offered colour, dwell counter and mode history
  always_ff @(posedge in_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_idx       <= '0;
      r_color     <= DEFAULT_PALETTE[COLOR_WIDTH-1:0];
      r_dwell     <= '0;
      r_mode_prev <= MODE_AUTO;
    end else begin
      r_dwell     <= w_dwell_nxt;
      r_mode_prev <= in_mode;
      if (w_advance) begin
        r_idx   <= w_next_idx;
        r_color <= w_color_nxt;
      end
    end
  end

  // Palette storage; out-of-range write addresses are dropped
  always_ff @(posedge in_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < N_COLORS; i++)
        r_palette[i] <= DEFAULT_PALETTE[i*COLOR_WIDTH +: COLOR_WIDTH];
    end else if (w_wr_hit) begin
      r_palette[in_wr_addr] <= in_wr_data;
    end
  end

  assign out_valid = (r_state == ST_PRESENT);
  assign out_color = r_color;
  assign out_index = r_idx;

endmodule

// File: tb/tb_fill_sequencer.sv
// Directed bench for fill_sequencer with a short dwell (4 clocks) and the
// default three-entry palette.
module tb_fill_sequencer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic        dir;
  logic        step;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        ready;
  logic [15:0] out_color;
  logic        out_valid;
  logic [1:0]  out_index;

  int n_cmp = 0;
  int n_err = 0;
  int n_gap;

  fill_sequencer #(
    .N_COLORS(3),
    .COLOR_WIDTH(16),
    .DWELL_CYCLES(4),
    .DEFAULT_PALETTE({16'h000f, 16'h03e0, 16'hf800})
  ) dut (
    .in_clk(clk),
    .in_rst_n(rst_n),
    .in_mode(mode),
    .in_dir(dir),
    .in_step(step),
    .in_wr_en(wr_en),
    .in_wr_addr(wr_addr),
    .in_wr_data(wr_data),
    .in_ready(ready),
    .out_color(out_color),
    .out_valid(out_valid),
    .out_index(out_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] idx,
                           input logic [15:0] col);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_index"}, 32'(out_index), 32'(idx));
    check({tag, "_color"}, 32'(out_color), 32'(col));
  endtask

  // accept current colour, then expect the next AUTO advance 4 clocks later
  task automatic do_auto(input string tag, input logic [1:0] idx, input logic [15:0] col);
    int n;
    tick();
    check({tag, "_accept"}, 32'(out_valid), 32'd0);
    wait_valid(20, n);
    check({tag, "_gap"}, 32'(n), 32'd4);
    check_out(tag, 1'b1, idx, col);
  endtask

  task automatic step_pulse();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd0; dir = 1'b0; step = 1'b0;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'h0; ready = 1'b0;

    // reset values
    repeat (2) tick();
    check_out("reset", 1'b1, 2'd0, 16'hf800);

    // case 1: AUTO, dir=0, pulses 5 clocks apart, wrap 2 -> 0
    ready = 1'b1;
    rst_n = 1'b1;
    repeat (2) tick();
    check_out("first_xfer", 1'b1, 2'd0, 16'hf800);
    do_auto("c1_a", 2'd1, 16'h03e0);
    do_auto("c1_b", 2'd2, 16'h000f);
    do_auto("c1_c", 2'd0, 16'hf800);

    // case 2: driver stalls for 10 clocks
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("c2_hold_valid", 32'(out_valid), 32'd1);
      check("c2_hold_color", 32'(out_color), 32'h0000f800);
    end
    ready = 1'b1;
    do_auto("c2_next", 2'd1, 16'h03e0);

    // case 4: write to the index currently presented
    ready = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    check_out("c4_wr", 1'b1, 2'd1, 16'h03e0);
    tick();
    check("c4_after", 32'(out_color), 32'h000003e0);
    ready = 1'b1;
    do_auto("c4_a", 2'd2, 16'h000f);
    do_auto("c4_b", 2'd0, 16'hf800);
    do_auto("c4_visit", 2'd1, 16'h1234);
    do_auto("c4_c", 2'd2, 16'h000f);
    do_auto("c4_d", 2'd0, 16'hf800);

    // case 3: STEP, dir=1
    mode = 2'd2; dir = 1'b1;
    tick();
    repeat (6) tick();
    check("c3_no_auto", 32'(out_valid), 32'd0);
    step_pulse();
    check_out("c3_s1", 1'b1, 2'd2, 16'h000f);
    ready = 1'b0;
    step_pulse();
    check_out("c3_extra", 1'b1, 2'd2, 16'h000f);
    ready = 1'b1;
    tick();
    check("c3_acc", 32'(out_valid), 32'd0);
    repeat (3) tick();
    check_out("c3_noqueue", 1'b0, 2'd2, 16'h000f);
    step_pulse();
    check_out("c3_s2", 1'b1, 2'd1, 16'h1234);
    tick();
    check("c3_acc2", 32'(out_valid), 32'd0);
    step_pulse();
    check_out("c3_s3", 1'b1, 2'd0, 16'hf800);

    // HOLD ignores in_step and does not dwell
    tick();
    mode = 2'd1;
    step_pulse();
    check_out("hold_step", 1'b0, 2'd0, 16'hf800);
    repeat (6) tick();
    check("hold_dwell", 32'(out_valid), 32'd0);

    // write and advance to the same entry on one edge
    mode = 2'd2; dir = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h5a5a;
    step_pulse();
    wr_en = 1'b0;
    check_out("wr_bypass", 1'b1, 2'd1, 16'h5a5a);

    // case 5: out-of-range write, then asynchronous reset mid-dwell
    mode = 2'd0;
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'hffff;
    tick();
    wr_en = 1'b0;
    check("c5_acc", 32'(out_valid), 32'd0);
    wait_valid(20, n_gap);
    check("c5_gap", 32'(n_gap), 32'd4);
    check_out("c5_e2", 1'b1, 2'd2, 16'h000f);
    do_auto("c5_e0", 2'd0, 16'hf800);
    do_auto("c5_e1", 2'd1, 16'h5a5a);
    repeat (3) tick();
    check("c5_middwell", 32'(out_valid), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check_out("c5_async_rst", 1'b1, 2'd0, 16'hf800);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check_out("c5_release", 1'b1, 2'd0, 16'hf800);
    do_auto("c5_pal1", 2'd1, 16'h03e0);
    do_auto("c5_pal2", 2'd2, 16'h000f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
